conv_channel_out_bias_relu: RTL and testbench
=============================================

# conv_channel_out_bias_relu

Per-output-channel bias add and ReLU stage placed directly downstream of the channel-in adder. It consumes the fully accumulated float32 pixel stream one output channel at a time: a full IMAGE_SIZE plane for channel 0, then channel 1, and so on. It adds the bias loaded for the current channel, clamps negative results to +0.0, and emits the activated stream with channel and frame markers for the next conv or pooling stage.

## Interface
Parameters:
- DATA_WIDTH, 32, IEEE-754 single-precision word width.
- IMAGE_SIZE, 128*128, pixels per output-channel plane.
- CHANNEL_NUM_OUT, 8, output channels per frame.
- POINTER_WIDTH, $clog2(IMAGE_SIZE)+1, width of the pixel counters.
- CH_WIDTH, $clog2(CHANNEL_NUM_OUT)+1, width of the channel counters and indices.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk, in, 1, sole clock; all state is on its rising edge.
  - reset_n, in, 1, clears all state immediately when 0.
- Input stream:
  - valid_in, in, 1, pxl_in qualifier; may be gapped arbitrarily.
  - pxl_in, in, DATA_WIDTH, accumulated conv sum.
- Bias load port:
  - bias_wr_en, in, 1, write strobe.
  - bias_wr_addr, in, CH_WIDTH, target channel (values ≥ CHANNEL_NUM_OUT are ignored).
  - bias_wr_data, in, DATA_WIDTH, float32 bias value.
- Output stream:
  - pxl_out, out, DATA_WIDTH, activated pixel; 0 whenever valid_out=0.
  - valid_out, out, 1, pxl_out qualifier.
  - ch_out, out, CH_WIDTH, channel index of the current pxl_out.
  - frame_done, out, 1, one-cycle pulse coincident with the last pixel of the last channel.

## Operation
- Bias file: CHANNEL_NUM_OUT × DATA_WIDTH registers, all reset to 0.
- Input side:
  - cnt_pxl_in (0..IMAGE_SIZE-1) and cnt_ch_in (0..CHANNEL_NUM_OUT-1) advance on each valid_in.
  - When cnt_pxl_in reaches IMAGE_SIZE-1, it wraps to 0 and cnt_ch_in increments.
  - cnt_ch_in wraps from CHANNEL_NUM_OUT-1 to 0.
- Stage 1 register captures valid_in, pxl_in and bias[cnt_ch_in].
- Adder: floating_point_1_add instance.
  - s_axis_a = stage-1 pixel; s_axis_b = stage-1 bias.
  - Both tvalid inputs = stage-1 valid; aresetn = reset_n.
- Stage 3 register takes the adder result and applies ReLU:
  - Sign bit 1: output 32'h0000_0000. This includes -0.0, negative infinity and negative-signed NaN.
  - Otherwise: the result passes unchanged.
- Output side:
  - cnt_pxl_out and cnt_ch_out count valid_out beats with the same wrap rules as the input side.
  - ch_out = cnt_ch_out.
  - frame_done = valid_out && cnt_pxl_out==IMAGE_SIZE-1 && cnt_ch_out==CHANNEL_NUM_OUT-1.
- No backpressure; the downstream stage must accept every valid_out beat.
- Bias write vs. read in the same cycle at the same address: stage 1 captures the old value; the new value applies from the next accepted pixel.
- Bias writes while streaming are legal. They take effect per-pixel, so software loads the bias between frames.

## Timing
- Latency: valid_in → valid_out = 2 + L cycles, where L is the configured floating_point_1_add latency.
- Throughput: one pixel per clock.
- Output ordering is identical to input ordering.
- Reset values:
  - pxl_out = 0, valid_out = 0, ch_out = 0, frame_done = 0.
  - All counters = 0; the bias file = 0.
- reset_n low mid-frame:
  - Pipeline and counters clear asynchronously, and in-flight pixels are dropped.
  - After release, the next valid_in is pixel 0 of channel 0.
- Wrap coincident with a bias write: handled independently. The counter wrap and the write both complete in the same cycle.

## Configuration
- CONV_OUT_RELU_EN defined:
  - ReLU is applied as specified above.
- CONV_OUT_RELU_EN undefined:
  - Stage 3 registers the adder result unchanged (linear output for projection layers).
  - Latency, counters, ch_out and frame_done are identical in both builds.

## Test plan
- Bias and ReLU (RELU_EN): load bias[0]=32'h3F80_0000 (1.0), then stream 32'h4000_0000 (2.0) and 32'hC040_0000 (-3.0). Required: 32'h4040_0000 (3.0), then 32'h0000_0000.
- Channel switching: IMAGE_SIZE=4, CHANNEL_NUM_OUT=2, bias[1]=-1.0, stream eight 1.0 inputs. Required: four outputs 2.0 with ch_out=0 (bias[0]=1.0), then four outputs 0.0 with ch_out=1. frame_done pulses only on the eighth output.
- Gapped input: same configuration, valid_in toggled 1,0,0,1,… Required: each output arrives exactly 2+L cycles after its input, with no duplicated or lost beats.
- Same-cycle bias write: write bias[0]=5.0 in the same cycle as a pixel on channel 0 with input 0.0. Required: that pixel → 1.0 (old bias); the next pixel → 5.0.
- Reset mid-frame: assert reset_n=0 after 3 inputs. Required: all outputs go to 0 immediately; after release, the first output has ch_out=0 and frame_done appears only after a full 8-pixel frame.
- Linear build (no CONV_OUT_RELU_EN): input -3.0 with bias 1.0. Required: 32'hC000_0000 (-2.0).

Source files
------------

// File: rtl/conv_channel_out_bias_relu_if.sv
// Stream, bias-load and activated-output bundle for conv_channel_out_bias_relu.
// master drives pixels and bias writes; slave is the bias/ReLU stage.
interface conv_channel_out_bias_relu_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CH_WIDTH   = 4
);
   logic                  valid_in;
   logic [DATA_WIDTH-1:0] pxl_in;
   logic                  bias_wr_en;
   logic [CH_WIDTH-1:0]   bias_wr_addr;
   logic [DATA_WIDTH-1:0] bias_wr_data;
   logic [DATA_WIDTH-1:0] pxl_out;
   logic                  valid_out;
   logic [CH_WIDTH-1:0]   ch_out;
   logic                  frame_done;

   modport master (
      output valid_in, pxl_in,
      output bias_wr_en, bias_wr_addr, bias_wr_data,
      input  pxl_out, valid_out, ch_out, frame_done
   );

   modport slave (
      input  valid_in, pxl_in,
      input  bias_wr_en, bias_wr_addr, bias_wr_data,
      output pxl_out, valid_out, ch_out, frame_done
   );
endinterface

// File: rtl/conv_channel_out_bias_relu.sv
// Per-channel float32 bias add + ReLU after the channel-in adder.
// Define CONV_OUT_RELU_EN for ReLU; undefined gives a linear output.
module floating_point_1_add (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        s_axis_a_tvalid,
   input  logic [31:0] s_axis_a_tdata,
   input  logic        s_axis_b_tvalid,
   input  logic [31:0] s_axis_b_tdata,
   output logic        m_axis_result_tvalid,
   output logic [31:0] m_axis_result_tdata
);
   logic [31:0]       a, b, big, sml, gen, res;
   logic              a_nan, b_nan, a_inf, b_inf;
   logic              a_zero, b_zero;
   logic [7:0]        d;
   logic [26:0]       ma, mb, n;
   logic [49:0]       bsh;
   logic [27:0]       sum;
   logic [4:0]        lz;
   logic [24:0]       m25;
   logic signed [9:0] er;

   // Round-to-nearest-even; subnormal inputs and results flush to zero
   always_comb begin
      a      = s_axis_a_tdata;
      b      = s_axis_b_tdata;
      a_nan  = (&a[30:23]) && (|a[22:0]);
      b_nan  = (&b[30:23]) && (|b[22:0]);
      a_inf  = (&a[30:23]) && !(|a[22:0]);
      b_inf  = (&b[30:23]) && !(|b[22:0]);
      a_zero = (a[30:23] == 8'd0);
      b_zero = (b[30:23] == 8'd0);
      if (b[30:0] > a[30:0]) begin
         big = b;
         sml = a;
      end else begin
         big = a;
         sml = b;
      end
      d   = big[30:23] - sml[30:23];
      ma  = {1'b1, big[22:0], 3'b000};
      bsh = {1'b1, sml[22:0], 26'd0} >> d;
      mb  = {bsh[49:24], (|bsh[23:0]) | (d > 8'd49)};
      if (big[31] == sml[31])
         sum = {1'b0, ma} + {1'b0, mb};
      else
         sum = {1'b0, ma} - {1'b0, mb};
      lz = 5'd0;
      for (int i = 0; i < 27; i++)
         if (sum[i]) lz = 5'(26 - i);
      if (sum[27]) begin
         n  = {sum[27:2], sum[1] | sum[0]};
         er = $signed({2'b00, big[30:23]}) + 10'sd1;
      end else begin
         n  = sum[26:0] << lz;
         er = $signed({2'b00, big[30:23]})
            - $signed({5'd0, lz});
      end
      m25 = {1'b0, n[26:3]}
          + {24'd0, n[2] & (n[1] | n[0] | n[3])};
      if (m25[24]) er = er + 10'sd1;
      if (sum == 28'd0)
         gen = 32'd0;
      else if (er <= 10'sd0)
         gen = {big[31], 31'd0};
      else if (er >= 10'sd255)
         gen = {big[31], 8'hFF, 23'd0};
      else
         gen = {big[31], er[7:0],
                m25[24] ? m25[23:1] : m25[22:0]};
      if (a_nan || b_nan || (a_inf && b_inf && a[31] != b[31]))
         res = 32'h7FC0_0000;
      else if (a_inf)
         res = a;
      else if (b_inf)
         res = b;
      else if (a_zero && b_zero)
         res = {a[31] & b[31], 31'd0};
      else if (a_zero)
         res = b;
      else if (b_zero)
         res = a;
      else
         res = gen;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_axis_result_tvalid <= 1'b0;
         m_axis_result_tdata  <= 32'd0;
      end else begin
         m_axis_result_tvalid <= s_axis_a_tvalid & s_axis_b_tvalid;
         m_axis_result_tdata  <= res;
      end
   end
endmodule

module conv_channel_out_bias_relu #(
   parameter int DATA_WIDTH      = 32,
   parameter int IMAGE_SIZE      = 128*128,
   parameter int CHANNEL_NUM_OUT = 8,
   parameter int POINTER_WIDTH   = $clog2(IMAGE_SIZE)+1,
   parameter int CH_WIDTH        = $clog2(CHANNEL_NUM_OUT)+1
) (
   input logic                     clk,
   input logic                     reset_n,
   conv_channel_out_bias_relu_if.slave bus
);
   localparam int IDX_W =
      (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
   localparam logic [POINTER_WIDTH-1:0] PXL_LAST =
      POINTER_WIDTH'(IMAGE_SIZE-1);
   localparam logic [CH_WIDTH-1:0] CH_LAST =
      CH_WIDTH'(CHANNEL_NUM_OUT-1);
   localparam logic [CH_WIDTH-1:0] CH_NUM =
      CH_WIDTH'(CHANNEL_NUM_OUT);

   logic [DATA_WIDTH-1:0]    bias_q [CHANNEL_NUM_OUT];
   logic [POINTER_WIDTH-1:0] cnt_pxl_in, cnt_pxl_out;
   logic [CH_WIDTH-1:0]      cnt_ch_in, cnt_ch_out;
   logic                     s1_valid, add_valid, valid_q;
   logic [DATA_WIDTH-1:0]    s1_pxl, s1_bias, add_data;
   logic [DATA_WIDTH-1:0]    act, pxl_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < CHANNEL_NUM_OUT; i++)
            bias_q[i] <= '0;
      end else if (bus.bias_wr_en && bus.bias_wr_addr < CH_NUM) begin
         bias_q[bus.bias_wr_addr[IDX_W-1:0]] <= bus.bias_wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_pxl_in <= '0;
         cnt_ch_in  <= '0;
      end else if (bus.valid_in) begin
         if (cnt_pxl_in == PXL_LAST) begin
            cnt_pxl_in <= '0;
            cnt_ch_in  <= (cnt_ch_in == CH_LAST) ? '0 : cnt_ch_in + 1'b1;
         end else begin
            cnt_pxl_in <= cnt_pxl_in + 1'b1;
         end
      end
   end

   // Bias is sampled with the pixel, so a same-cycle write lands next pixel
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_pxl   <= '0;
         s1_bias  <= '0;
      end else begin
         s1_valid <= bus.valid_in;
         s1_pxl   <= bus.pxl_in;
         s1_bias  <= bias_q[cnt_ch_in[IDX_W-1:0]];
      end
   end

   floating_point_1_add u_add (
      .aclk                 (clk),
      .aresetn              (reset_n),
      .s_axis_a_tvalid      (s1_valid),
      .s_axis_a_tdata       (s1_pxl),
      .s_axis_b_tvalid      (s1_valid),
      .s_axis_b_tdata       (s1_bias),
      .m_axis_result_tvalid (add_valid),
      .m_axis_result_tdata  (add_data)
   );

`ifdef CONV_OUT_RELU_EN
   assign act = add_data[DATA_WIDTH-1] ? '0 : add_data;
`else
   assign act = add_data;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         pxl_q   <= '0;
      end else begin
         valid_q <= add_valid;
         pxl_q   <= add_valid ? act : '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_pxl_out <= '0;
         cnt_ch_out  <= '0;
      end else if (valid_q) begin
         if (cnt_pxl_out == PXL_LAST) begin
            cnt_pxl_out <= '0;
            cnt_ch_out  <= (cnt_ch_out == CH_LAST) ? '0 : cnt_ch_out + 1'b1;
         end else begin
            cnt_pxl_out <= cnt_pxl_out + 1'b1;
         end
      end
   end

   assign bus.valid_out  = valid_q;
   assign bus.pxl_out    = pxl_q;
   assign bus.ch_out     = cnt_ch_out;
   assign bus.frame_done = valid_q && cnt_pxl_out == PXL_LAST
                        && cnt_ch_out == CH_LAST;
endmodule

// File: tb/tb_conv_channel_out_bias_relu.sv
// Bench for conv_channel_out_bias_relu: small planes, integer-valued floats,
// scoreboard of expected beats with arrival cycle, channel and frame marker.
module tb_conv_channel_out_bias_relu;
   localparam int IMG = 4;
   localparam int CHN = 2;
   localparam int CHW = 2;
   localparam int LAT = 3;

   typedef struct packed {
      int          idx;
      logic [31:0] pxl;
      logic [1:0]  ch;
      logic        fd;
   } beat_t;

   logic  clk = 1'b0;
   logic  reset_n = 1'b1;
   int    nrun = 0;
   int    nfail = 0;
   int    nidx = 0;
   int    in_cnt = 0;
   int    idle_bad = 0;
   int    bi [CHN];
   beat_t expq [$];
   beat_t obs [$];

   always #5 clk = ~clk;

   conv_channel_out_bias_relu_if #(.DATA_WIDTH(32), .CH_WIDTH(CHW)) bus ();

   conv_channel_out_bias_relu #(
      .DATA_WIDTH      (32),
      .IMAGE_SIZE      (IMG),
      .CHANNEL_NUM_OUT (CHN),
      .POINTER_WIDTH   (3),
      .CH_WIDTH        (CHW)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   function automatic logic [31:0] int2f(int x);
      logic [31:0] a, f;
      int msb;
      if (x == 0) return 32'd0;
      a = (x < 0) ? -x : x;
      msb = 0;
      for (int i = 0; i < 24; i++) if (a[i]) msb = i;
      f = a << (23 - msb);
      return {x < 0, 8'(127 + msb), f[22:0]};
   endfunction

   function automatic logic [31:0] act(logic [31:0] f);
`ifdef CONV_OUT_RELU_EN
      return f[31] ? 32'd0 : f;
`else
      return f;
`endif
   endfunction

   function automatic int cur_ch();
      return (in_cnt / IMG) % CHN;
   endfunction

   task automatic tick(input logic v, input logic [31:0] p,
                       input logic [31:0] e);
      @(negedge clk);
      nidx++;
      if (bus.valid_out)
         obs.push_back('{nidx, bus.pxl_out, bus.ch_out, bus.frame_done});
      else if (bus.pxl_out !== 32'd0 || bus.frame_done !== 1'b0)
         idle_bad++;
      bus.bias_wr_en = 1'b0;
      bus.valid_in = v;
      bus.pxl_in = p;
      if (v) begin
         expq.push_back('{nidx + LAT, e, 2'(cur_ch()),
                          (in_cnt % (IMG*CHN)) == IMG*CHN - 1});
         in_cnt++;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.bias_wr_en = 1'b1;
      bus.bias_wr_addr = a;
      bus.bias_wr_data = d;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      bus.valid_in = 1'b0;
      bus.pxl_in = 32'd0;
      bus.bias_wr_en = 1'b0;
      repeat (2) @(negedge clk);
      expq.delete();
      obs.delete();
      in_cnt = 0;
      idle_bad = 0;
      for (int c = 0; c < CHN; c++) bi[c] = 0;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.valid_in = 1'b0;
      bus.pxl_in = 32'd0;
      bus.bias_wr_en = 1'b0;
      bus.bias_wr_addr = '0;
      bus.bias_wr_data = 32'd0;
      #2 reset_n = 1'b0;
      #1;
      nrun++;
      if (bus.pxl_out !== 32'd0) begin
         nfail++;
         $display("FAIL reset pxl_out: got %h want 0", bus.pxl_out);
      end
      nrun++;
      if (bus.valid_out !== 1'b0) begin
         nfail++;
         $display("FAIL reset valid_out: got %b want 0", bus.valid_out);
      end
      nrun++;
      if (bus.ch_out !== 2'd0) begin
         nfail++;
         $display("FAIL reset ch_out: got %0d want 0", bus.ch_out);
      end
      nrun++;
      if (bus.frame_done !== 1'b0) begin
         nfail++;
         $display("FAIL reset frame_done: got %b want 0", bus.frame_done);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_bias_relu();
      do_reset();
      tick(1'b0, 32'd0, 32'd0);
      wr(2'd0, 32'h3F80_0000);
      tick(1'b1, 32'h4000_0000, 32'h4040_0000);
      tick(1'b1, 32'hC040_0000, act(32'hC000_0000));
      repeat (6) tick(1'b0, 32'd0, 32'd0);
      nrun++;
      if (obs.size() != expq.size()) begin
         nfail++;
         $display("FAIL bias_relu count: got %0d want %0d", obs.size(), expq.size());
      end
      foreach (expq[i]) if (i < obs.size()) begin
         nrun++;
         if (obs[i] !== expq[i]) begin
            nfail++;
            $display("FAIL bias_relu beat %0d: got %p want %p", i, obs[i], expq[i]);
         end
      end
   endtask

   task automatic test_channels();
      do_reset();
      tick(1'b0, 32'd0, 32'd0);
      wr(2'd0, 32'h3F80_0000);
      tick(1'b0, 32'd0, 32'd0);
      wr(2'd1, 32'hBF80_0000);
      for (int i = 0; i < IMG*CHN; i++)
         tick(1'b1, 32'h3F80_0000,
              cur_ch() == 0 ? 32'h4000_0000 : 32'h0000_0000);
      repeat (6) tick(1'b0, 32'd0, 32'd0);
      nrun++;
      if (obs.size() != expq.size()) begin
         nfail++;
         $display("FAIL channels count: got %0d want %0d", obs.size(), expq.size());
      end
      foreach (expq[i]) if (i < obs.size()) begin
         nrun++;
         if (obs[i] !== expq[i]) begin
            nfail++;
            $display("FAIL channels beat %0d: got %p want %p", i, obs[i], expq[i]);
         end
      end
   endtask

   task automatic test_gapped();
      int p, b;
      do_reset();
      for (int c = 0; c < CHN; c++) begin
         b = int'($urandom_range(100)) - 50;
         tick(1'b0, 32'd0, 32'd0);
         wr(2'(c), int2f(b));
         bi[c] = b;
      end
      for (int i = 0; i < 3*IMG*CHN*3; i++) begin
         p = int'($urandom_range(400)) - 200;
         tick(i % 3 == 0, int2f(p), act(int2f(p + bi[cur_ch()])));
      end
      repeat (6) tick(1'b0, 32'd0, 32'd0);
      nrun++;
      if (obs.size() != expq.size()) begin
         nfail++;
         $display("FAIL gapped count: got %0d want %0d", obs.size(), expq.size());
      end
      foreach (expq[i]) if (i < obs.size()) begin
         nrun++;
         if (obs[i] !== expq[i]) begin
            nfail++;
            $display("FAIL gapped beat %0d: got %p want %p", i, obs[i], expq[i]);
         end
      end
      nrun++;
      if (idle_bad != 0) begin
         nfail++;
         $display("FAIL gapped idle: got %0d dirty idle cycles want 0", idle_bad);
      end
   endtask

   task automatic test_random_stream();
      int p, b;
      logic [1:0] a;
      do_reset();
      for (int i = 0; i < 120; i++) begin
         p = int'($urandom_range(400)) - 200;
         tick($urandom_range(1) == 1, int2f(p),
              act(int2f(p + bi[cur_ch()])));
         if ($urandom_range(3) == 0) begin
            a = 2'($urandom_range(3));
            b = int'($urandom_range(100)) - 50;
            wr(a, int2f(b));
            if (a < CHN) bi[a] = b;
         end
      end
      repeat (6) tick(1'b0, 32'd0, 32'd0);
      nrun++;
      if (obs.size() != expq.size()) begin
         nfail++;
         $display("FAIL random count: got %0d want %0d", obs.size(), expq.size());
      end
      foreach (expq[i]) if (i < obs.size()) begin
         nrun++;
         if (obs[i] !== expq[i]) begin
            nfail++;
            $display("FAIL random beat %0d: got %p want %p", i, obs[i], expq[i]);
         end
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      tick(1'b0, 32'd0, 32'd0);
      wr(2'd0, 32'h3F80_0000);
      tick(1'b1, 32'h0000_0000, 32'h3F80_0000);
      wr(2'd0, 32'h40A0_0000);
      tick(1'b1, 32'h0000_0000, 32'h40A0_0000);
      repeat (6) tick(1'b0, 32'd0, 32'd0);
      nrun++;
      if (obs.size() != expq.size()) begin
         nfail++;
         $display("FAIL same_cycle count: got %0d want %0d", obs.size(), expq.size());
      end
      foreach (expq[i]) if (i < obs.size()) begin
         nrun++;
         if (obs[i] !== expq[i]) begin
            nfail++;
            $display("FAIL same_cycle beat %0d: got %p want %p", i, obs[i], expq[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 3; i++)
         tick(1'b1, 32'h3F80_0000, 32'h3F80_0000);
      @(posedge clk);
      #1;
      nrun++;
      if (bus.valid_out !== 1'b1) begin
         nfail++;
         $display("FAIL reset_mid inflight: got valid_out=%b want 1", bus.valid_out);
      end
      reset_n = 1'b0;
      #1;
      nrun++;
      if ({bus.pxl_out, bus.valid_out, bus.ch_out, bus.frame_done} !== 36'd0) begin
         nfail++;
         $display("FAIL reset_mid clear: got pxl=%h v=%b ch=%0d fd=%b want all 0",
                  bus.pxl_out, bus.valid_out, bus.ch_out, bus.frame_done);
      end
      bus.valid_in = 1'b0;
      repeat (2) @(negedge clk);
      expq.delete();
      obs.delete();
      in_cnt = 0;
      reset_n = 1'b1;
      for (int i = 0; i < IMG*CHN; i++)
         tick(1'b1, 32'h3F80_0000, 32'h3F80_0000);
      repeat (6) tick(1'b0, 32'd0, 32'd0);
      nrun++;
      if (obs.size() != expq.size()) begin
         nfail++;
         $display("FAIL reset_mid count: got %0d want %0d", obs.size(), expq.size());
      end
      foreach (expq[i]) if (i < obs.size()) begin
         nrun++;
         if (obs[i] !== expq[i]) begin
            nfail++;
            $display("FAIL reset_mid beat %0d: got %p want %p", i, obs[i], expq[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_bias_relu();
      test_channels();
      test_gapped();
      test_random_stream();
      test_same_cycle();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", nrun, nfail);
      $finish;
   end
endmodule
